// File: rtl/bp_common_pkg.sv
// Shared types for the commit monitor: the captured commit record layout,
// the watchdog state encoding, and a saturating counter helper.
package bp_common_pkg;

    localparam int bp_vaddr_width_gp = 39;
    localparam int bp_instr_width_gp = 32;
    localparam int bp_stamp_width_gp = 32;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_run  = 2'd1,
        e_hung = 2'd2
    } bp_commit_mon_state_e;

    typedef struct packed {
        logic [bp_stamp_width_gp-1:0] stamp;
        logic                         trap_exc;
        logic                         trap_int;
        logic [bp_vaddr_width_gp-1:0] pc;
        logic [bp_instr_width_gp-1:0] instr;
    } bp_commit_rec_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/bp_nonsynth_commit_monitor_chk.sv
// Protocol checker for the commit monitor drain interface.
module bp_nonsynth_commit_monitor_chk (
    input logic clk,
    input logic reset,
    input logic v,
    input logic yumi
);

    // The consumer may only take a head record that is actually valid
    always @(posedge clk) begin
        if (reset) begin
            assert (!(yumi && !v)) else $error("commit monitor: yumi asserted while v_o is low");
        end
    end

endmodule

// File: rtl/bp_nonsynth_commit_watchdog.sv
// Commit-hang watchdog: arms on the first commit, counts idle cycles while
// enabled, and latches HUNG permanently once timeout_p idle cycles elapse.
module bp_nonsynth_commit_watchdog
    import bp_common_pkg::*;
#(
    parameter int timeout_p = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       evt,
    input  logic       en,
    output logic [1:0] state,
    output logic       hang
);

    localparam int cw = $clog2(timeout_p + 1);
    localparam logic [cw-1:0] last_idle = cw'(timeout_p - 1);

    bp_commit_mon_state_e state_r, state_n;
    logic [cw-1:0]        idle_cnt_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= e_idle;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle: begin
                if (evt) state_n = e_run;
                else     state_n = e_idle;
            end
            e_run: begin
                if (!en)                             state_n = e_idle;
                else if (!evt && idle_cnt_r == last_idle) state_n = e_hung;
                else                                 state_n = e_run;
            end
            e_hung:  state_n = e_hung;
            default: state_n = e_idle;
        endcase
    end

    // Idle counter: only advances on quiet cycles that stay in RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_r <= '0;
        end else if (state_r == e_run && state_n == e_run && !evt) begin
            idle_cnt_r <= idle_cnt_r + cw'(1);
        end else begin
            idle_cnt_r <= '0;
        end
    end

    // Output decode from the state register
    always_comb begin
        state = state_r;
        hang  = (state_r == e_hung);
    end

endmodule

// File: rtl/bp_nonsynth_commit_monitor.sv
// Commit capture stage: stamps BE commit events, queues them in order and
// exposes them on a valid/yumi port, with overflow and hang detection.
module bp_nonsynth_commit_monitor
    import bp_common_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int els_p         = 16,
    parameter int timeout_p     = 4096,
    parameter int stamp_width_p = 32
) (
    input  logic                                                    clk_i,
    input  logic                                                    reset_i,
    input  logic                                                    en_i,
    input  logic                                                    instret_i,
    input  logic                                                    exception_i,
    input  logic                                                    interrupt_i,
    input  logic [vaddr_width_p-1:0]                                pc_i,
    input  logic [instr_width_p-1:0]                                instr_i,
    output logic                                                    v_o,
    output logic [stamp_width_p+2+vaddr_width_p+instr_width_p-1:0]  data_o,
    input  logic                                                    yumi_i,
    output logic                                                    overflow_o,
    output logic [15:0]                                             drop_cnt_o,
    output logic                                                    hang_o,
    output logic [1:0]                                              state_o
);

    localparam int aw = $clog2(els_p);
    localparam int pw = aw + 1;
    localparam int dw = stamp_width_p + 2 + vaddr_width_p + instr_width_p;

    logic [dw-1:0]            mem_r [els_p];
    logic [pw-1:0]            wr_ptr_r, rd_ptr_r;
    logic [stamp_width_p-1:0] stamp_r;
    logic [15:0]              drop_cnt_r;
    logic                     overflow_r;

    logic          evt_s, empty_s, full_s, push_s, pop_s, drop_s;
    logic [dw-1:0] rec_s;

    assign evt_s   = en_i & (instret_i | exception_i | interrupt_i);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[aw] != rd_ptr_r[aw]) && (wr_ptr_r[aw-1:0] == rd_ptr_r[aw-1:0]);
    assign pop_s   = yumi_i & ~empty_s;
    // A pop in the same cycle frees the slot, so a push at full is still accepted
    assign push_s  = evt_s & (~full_s | pop_s);
    assign drop_s  = evt_s & full_s & ~yumi_i;
    assign rec_s   = {stamp_r, exception_i, interrupt_i, pc_i, instr_i};

    // Free-running cycle stamp
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stamp_r <= '0;
        end else begin
            stamp_r <= stamp_r + stamp_width_p'(1);
        end
    end

    // Ring-buffer pointers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + pw'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + pw'(1);
        end
    end

    // Record storage; stale contents are masked on the output while empty
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r[aw-1:0]] <= rec_s;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= sat_inc16(drop_cnt_r);
        end
    end

    // Head presentation
    always_comb begin
        v_o = ~empty_s;
        if (empty_s) data_o = '0;
        else         data_o = mem_r[rd_ptr_r[aw-1:0]];
    end

    assign overflow_o = overflow_r;
    assign drop_cnt_o = drop_cnt_r;

    bp_nonsynth_commit_watchdog #(
        .timeout_p(timeout_p)
    ) u_watchdog (
        .clk   (clk_i),
        .reset (reset_i),
        .evt   (evt_s),
        .en    (en_i),
        .state (state_o),
        .hang  (hang_o)
    );

    bp_nonsynth_commit_monitor_chk u_chk (
        .clk   (clk_i),
        .reset (reset_i),
        .v     (v_o),
        .yumi  (yumi_i)
    );

endmodule

// File: tb/tb_bp_nonsynth_commit_monitor.sv
// Directed bench for bp_nonsynth_commit_monitor with a queue scoreboard of
// expected records and models of the stamp and drop counters.
module tb_bp_nonsynth_commit_monitor;
    import bp_common_pkg::*;

    localparam int VA  = 39;
    localparam int IW  = 32;
    localparam int SW  = 32;
    localparam int ELS = 16;
    localparam int TO  = 8;
    localparam int DW  = SW + 2 + VA + IW;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          en = 1'b1;
    logic          instret = 1'b0;
    logic          exc = 1'b0;
    logic          intr = 1'b0;
    logic          yumi = 1'b0;
    logic [VA-1:0] pc = '0;
    logic [IW-1:0] instr = '0;

    logic          v_o;
    logic [DW-1:0] data_o;
    logic          ovf;
    logic [15:0]   drop;
    logic          hang;
    logic [1:0]    state;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] sb[$];
    logic [SW-1:0] stamp_m = '0;
    logic [15:0]   drop_m = 16'd0;
    logic          ovf_m = 1'b0;
    bit            drain = 1'b0;
    bp_commit_rec_s rec;

    always #5 clk = ~clk;

    bp_nonsynth_commit_monitor #(
        .vaddr_width_p(VA),
        .instr_width_p(IW),
        .els_p        (ELS),
        .timeout_p    (TO),
        .stamp_width_p(SW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .en_i       (en),
        .instret_i  (instret),
        .exception_i(exc),
        .interrupt_i(intr),
        .pc_i       (pc),
        .instr_i    (instr),
        .v_o        (v_o),
        .data_o     (data_o),
        .yumi_i     (yumi),
        .overflow_o (ovf),
        .drop_cnt_o (drop),
        .hang_o     (hang),
        .state_o    (state)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ev(input logic r, input logic e, input logic i,
                          input logic [VA-1:0] p, input logic [IW-1:0] ins);
        instret = r;
        exc     = e;
        intr    = i;
        pc      = p;
        instr   = ins;
    endtask

    // One clock: check head/valid, update scoreboard, advance, check counters
    task automatic cycle();
        logic ev;
        yumi = drain && (sb.size() != 0);
        chk("v_o", v_o, sb.size() != 0);
        if (yumi) begin
            chk("head", data_o, sb[0]);
            void'(sb.pop_front());
        end
        ev = en & (instret | exc | intr);
        if (ev) begin
            if (sb.size() < ELS) begin
                sb.push_back({stamp_m, exc, intr, pc, instr});
            end else begin
                ovf_m = 1'b1;
                if (drop_m != 16'hFFFF) drop_m++;
            end
        end
        @(posedge clk);
        stamp_m++;
        @(negedge clk);
        chk("overflow", ovf, ovf_m);
        chk("drop_cnt", drop, drop_m);
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        set_ev(1'b0, 1'b0, 1'b0, '0, '0);
        drain = 1'b0;
        yumi  = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_v", v_o, 1'b0);
        chk("rst_data", data_o, '0);
        chk("rst_hang", hang, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_state", state, 2'd0);
        chk("rst_drop", drop, 16'd0);
        sb.delete();
        stamp_m = '0;
        drop_m  = 16'd0;
        ovf_m   = 1'b0;
        reset_i = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();

        // In-order capture with continuous draining, plus one interrupt
        drain = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_ev(1'b1, 1'b0, 1'b0, 39'h1000 + 39'(4 * i), 32'h00000013 + 32'(i));
            cycle();
        end
        set_ev(1'b0, 1'b0, 1'b1, 39'h1100, 32'h0);
        cycle();
        set_ev(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) cycle();
        chk("ord_empty", v_o, 1'b0);

        // Overflow: 20 events into 16 slots with no draining
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_ev(1'b1, 1'b0, 1'b0, 39'h2000 + 39'(4 * i), 32'(i));
            cycle();
        end
        chk("ovf_drop4", drop, 16'd4);
        chk("ovf_flag", ovf, 1'b1);
        chk("ovf_count", sb.size(), ELS);
        drain = 1'b1;
        set_ev(1'b1, 1'b0, 1'b0, 39'h2100, 32'hABCD);
        cycle();
        chk("pushpop_full_drop", drop, 16'd4);
        set_ev(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (17) cycle();
        chk("ovf_drained", v_o, 1'b0);

        // Watchdog timeout and absorbing HUNG
        do_reset();
        set_ev(1'b1, 1'b0, 1'b0, 39'h3000, 32'h13);
        cycle();
        set_ev(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (7) cycle();
        chk("wd_run_before", state, 2'd1);
        chk("wd_nohang_before", hang, 1'b0);
        cycle();
        chk("wd_hung", state, 2'd2);
        chk("wd_hang", hang, 1'b1);
        set_ev(1'b1, 1'b0, 1'b0, 39'h3004, 32'h33);
        cycle();
        set_ev(1'b0, 1'b0, 1'b0, '0, '0);
        chk("wd_hang_sticky", hang, 1'b1);
        chk("wd_still_captures", sb.size(), 2);
        drain = 1'b1;
        repeat (3) cycle();
        chk("wd_hung_final", state, 2'd2);

        // Exception record fields and enable drop
        do_reset();
        set_ev(1'b0, 1'b1, 1'b0, 39'h80000000, 32'h00100073);
        cycle();
        chk("trap_state_run", state, 2'd1);
        rec = bp_commit_rec_s'(data_o);
        chk("trap_exc", rec.trap_exc, 1'b1);
        chk("trap_int", rec.trap_int, 1'b0);
        chk("trap_pc", rec.pc, 39'h80000000);
        chk("trap_stamp", rec.stamp, 32'd0);
        set_ev(1'b0, 1'b0, 1'b0, '0, '0);
        en = 1'b0;
        drain = 1'b1;
        cycle();
        chk("en_off_idle", state, 2'd0);
        cycle();

        // Asynchronous reset between edges with records queued
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_ev(1'b1, 1'b0, 1'b0, 39'h4000 + 39'(4 * i), 32'(i + 100));
            cycle();
        end
        set_ev(1'b0, 1'b0, 1'b0, '0, '0);
        chk("async_pre_v", v_o, 1'b1);
        #2;
        reset_i = 1'b0;
        #1;
        chk("async_v", v_o, 1'b0);
        chk("async_data", data_o, '0);
        chk("async_state", state, 2'd0);
        @(negedge clk);
        do_reset();
        drain = 1'b1;
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
